// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, followed by a sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               busy_q, busy_d, done_q, done_d, dz_out_q, dz_out_d;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH+1:0]   shifted, diff;
  logic [2*WIDTH-1:0] prod;

  assign sgn_a   = ~op[0] & operand_a[WIDTH-1];
  assign sgn_b   = ~op[0] & operand_b[WIDTH-1];
  assign mag_a   = sgn_a ? -operand_a : operand_a;
  assign mag_b   = sgn_b ? -operand_b : operand_b;
  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  // remainder shifted left with the next dividend bit; top bit doubles as the borrow
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign diff    = shifted - {2'b00, opnd_q};
  assign prod    = neg_res_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_out_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = mt_data;
        if (lo_we) lo_d = mt_data;
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          cnt_d     = '0;
          rem_d     = '0;
          dbz_d     = 1'b0;
          if (!op[1]) begin
            opnd_d  = mag_a;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = S_MUL;
          end else if (operand_b == '0) begin
            // raw dividend and all-ones quotient go straight to HI/LO
            acc_d   = {operand_a, {WIDTH{1'b1}}};
            dbz_d   = 1'b1;
            state_d = S_FIX;
          end else begin
            opnd_d  = mag_b;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!diff[WIDTH+1]) begin
          rem_d              = diff[WIDTH:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d              = shifted[WIDTH:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      default: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        dz_out_d = dbz_q;
        if (dbz_q) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end else if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          hi_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          lo_d = prod[WIDTH-1:0];
        end
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_out_q  <= dz_out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboarded random/directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  operand_a = '0, operand_b = '0, mt_data = '0;
  logic          hi_we = 1'b0, lo_we = 1'b0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_we(hi_we), .lo_we(lo_we), .mt_data(mt_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0, fails = 0, cyc = 0, pushed = 0, seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    e.cyc = cyc + W + 2;
    if (!o[1]) begin
      if (!o[0]) p = 64'(sa * sb);
      else       p = {32'd0, a} * {32'd0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
      e.cyc = cyc + 2;
    end else if (!o[0]) begin
      q = sa / sb;
      r = sa % sb;
      p = 64'(q); e.lo = p[31:0];
      p = 64'(r); e.hi = p[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      seen++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
      fails++; tests++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    exp_q.push_back(model(o, a, b));
    pushed++;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFFFFFF; sp[3] = 32'h80000000; sp[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return W'($urandom_range(0, 300)) - W'(150);
    return $urandom;
  endfunction

  initial begin
    logic [W-1:0] hold;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("busy_after_start", 64'(busy), 64'd1);
    issue(2'b00, 32'hFFFFFFFD, 32'd5);
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    issue(2'b11, 32'd7, 32'd2);
    issue(2'b11, 32'd100, 32'd0);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);

    // second start while busy must be dropped
    issue(2'b01, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    chk("busy_mid_op", 64'(busy), 64'd1);
    start = 1'b1; op = 2'b00; operand_a = 32'd2; operand_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    hi_we = 1'b1; mt_data = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; mt_data = 32'h5678;
    chk("mthi", 64'(hi), 64'h1234);
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", 64'(lo), 64'h5678);

    issue(2'b01, 32'd3, 32'd3);
    hold = hi;
    hi_we = 1'b1; mt_data = 32'hDEAD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_while_busy", 64'(hi), 64'(hold));
    wait_idle();

    // asynchronous reset in the middle of an operation
    issue(2'b01, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    exp_q.delete();
    pushed--;
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'd3, 32'd3);

    for (int i = 0; i < 60; i++) begin
      logic [1:0] o;
      logic [W-1:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      issue(o, a, b);
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        @(negedge clk);
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(seen), 64'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
